// File: rtl/serial_xfer_pkg.sv
// Shared definitions for the two-requester serial transfer arbiter:
// state encoding, shift direction and requester identifiers.
package serial_xfer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    function automatic logic [1:0] onehot_gnt(input logic id);
        return (id == REQ_B) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/serial_xfer_arb_if.sv
// Client-side bundle of the serial transfer arbiter: requests, parallel words,
// serial link and completion reporting.
interface serial_xfer_arb_if #(
    parameter int N = 4
);
    logic [1:0]   req;
    logic [1:0]   dir;
    logic [N-1:0] tx_a;
    logic [N-1:0] tx_b;
    logic         sin;
    logic [1:0]   gnt;
    logic         busy;
    logic         sout;
    logic         done;
    logic         done_id;
    logic [N-1:0] rx_word;

    modport master (
        output req, dir, tx_a, tx_b, sin,
        input  gnt, busy, sout, done, done_id, rx_word
    );

    modport slave (
        input  req, dir, tx_a, tx_b, sin,
        output gnt, busy, sout, done, done_id, rx_word
    );
endinterface

// File: rtl/xfer_shift_core.sv
// N-bit loadable bidirectional shift register; load has priority over shift.
module xfer_shift_core
    import serial_xfer_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic         dir,
    input  logic         sin,
    input  logic [N-1:0] load_word,
    output logic [N-1:0] q,
    output logic         sout
);
    logic [N-1:0] q_reg;
    logic [N-1:0] q_next;
    logic [N-1:0] shifted;

    // Each bit takes its upper neighbour on a right shift, lower on a left shift.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            logic from_hi;
            logic from_lo;
            if (gi == N - 1) begin : g_top
                assign from_hi = sin;
            end else begin : g_mid_hi
                assign from_hi = q_reg[gi+1];
            end
            if (gi == 0) begin : g_bot
                assign from_lo = sin;
            end else begin : g_mid_lo
                assign from_lo = q_reg[gi-1];
            end
            assign shifted[gi] = (dir == DIR_RIGHT) ? from_hi : from_lo;
        end
    endgenerate

    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = load_word;
        end else if (shift_en) begin
            q_next = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q    = q_reg;
    assign sout = (dir == DIR_RIGHT) ? q_reg[0] : q_reg[N-1];

endmodule

// File: rtl/serial_xfer_arb.sv
// Round-robin arbiter and sequencer: grants one requester, shifts its word
// out over N cycles while capturing sin, then reports the received word.
module serial_xfer_arb
    import serial_xfer_pkg::*;
#(
    parameter int N = 4
) (
    input logic            clk,
    input logic            rst,
    serial_xfer_arb_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    state_t       state_reg;
    logic [CW-1:0] cnt_reg;
    logic         ptr_reg;
    logic         owner_reg;
    logic         dir_reg;
    logic [1:0]   gnt_reg;
    logic         busy_reg;
    logic         done_reg;
    logic         done_id_reg;
    logic [N-1:0] rx_reg;

    logic         owner_next;
    logic         grant;
    logic         core_sout;
    logic [N-1:0] q;
    logic [N-1:0] load_word;
    logic [N-1:0] final_word;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        owner_next = ptr_reg;
        if (bus.req == 2'b01) begin
            owner_next = REQ_A;
        end else if (bus.req == 2'b10) begin
            owner_next = REQ_B;
        end
    end

    assign grant      = (state_reg == IDLE) && (bus.req != 2'b00);
    assign load_word  = (owner_next == REQ_B) ? bus.tx_b : bus.tx_a;
    assign final_word = (dir_reg == DIR_RIGHT) ? {bus.sin, q[N-1:1]} : {q[N-2:0], bus.sin};

    xfer_shift_core #(.N(N)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (grant),
        .shift_en  (state_reg == SHIFT),
        .dir       (dir_reg),
        .sin       (bus.sin),
        .load_word (load_word),
        .q         (q),
        .sout      (core_sout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ptr_reg     <= REQ_A;
            owner_reg   <= REQ_A;
            dir_reg     <= DIR_LEFT;
            gnt_reg     <= 2'b00;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            done_id_reg <= 1'b0;
            rx_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        gnt_reg   <= onehot_gnt(owner_next);
                        owner_reg <= owner_next;
                        dir_reg   <= bus.dir[owner_next];
                        ptr_reg   <= ~owner_next;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(N - 1)) begin
                        rx_reg      <= final_word;
                        done_reg    <= 1'b1;
                        done_id_reg <= owner_reg;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    gnt_reg   <= 2'b00;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_reg;
    assign bus.busy    = busy_reg;
    assign bus.sout    = (state_reg == SHIFT) ? core_sout : 1'b0;
    assign bus.done    = done_reg;
    assign bus.done_id = done_id_reg;
    assign bus.rx_word = rx_reg;

endmodule

// File: tb/tb_serial_xfer_arb.sv
// Bench for serial_xfer_arb: directed scenarios plus random traffic against a
// transfer-level model of grants, serial bit order and received words.
module tb_serial_xfer_arb;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_xfer_arb_if #(.N(N)) bus ();

    serial_xfer_arb #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // model: phase 0 idle, 1..N about to shift bit 'phase', N+1 done cycle
    int           phase;
    int           m_owner;
    int           m_ptr;
    logic         m_dir;
    logic [N-1:0] m_word;
    logic [N-1:0] m_rx;
    logic         m_done_id;
    bit           s_bits[1:N];
    int           cyc = 0;

    int   done_count = 0;
    logic [1:0] prev_gnt = 2'b00;
    int   gq_val[$];
    int   gq_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        phase     = 0;
        m_owner   = 0;
        m_ptr     = 0;
        m_rx      = '0;
        m_done_id = 1'b0;
    endtask

    task automatic check_outputs();
        logic [1:0] e_gnt;
        logic       e_sout;
        e_gnt  = (phase > 0) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        e_sout = 1'b0;
        if (phase >= 1 && phase <= N)
            e_sout = m_dir ? m_word[phase-1] : m_word[N-phase];
        chk("gnt",     bus.gnt,     e_gnt);
        chk("busy",    bus.busy,    phase > 0);
        chk("sout",    bus.sout,    e_sout);
        chk("done",    bus.done,    phase == N + 1);
        chk("done_id", bus.done_id, m_done_id);
        chk("rx_word", bus.rx_word, m_rx);
        if (bus.done === 1'b1) done_count++;
        if (bus.gnt != 2'b00 && prev_gnt == 2'b00) begin
            gq_val.push_back(int'(bus.gnt));
            gq_cyc.push_back(cyc);
        end
        prev_gnt = bus.gnt;
    endtask

    task automatic model_edge();
        cyc++;
        if (!rst) begin
            model_reset();
            return;
        end
        if (phase == 0) begin
            if (bus.req != 2'b00) begin
                m_owner = (bus.req == 2'b01) ? 0 : (bus.req == 2'b10) ? 1 : m_ptr;
                m_ptr   = 1 - m_owner;
                m_word  = (m_owner == 1) ? bus.tx_b : bus.tx_a;
                m_dir   = bus.dir[m_owner];
                phase   = 1;
            end
        end else if (phase <= N) begin
            s_bits[phase] = bus.sin;
            phase++;
            if (phase == N + 1) begin
                for (int i = 0; i < N; i++)
                    m_rx[i] = m_dir ? s_bits[i+1] : s_bits[N-i];
                m_done_id = (m_owner == 1);
                $display("xfer owner=%0d dir=%0d word=%h rx=%h", m_owner, m_dir, m_word, m_rx);
            end
        end else begin
            phase = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        #1;
        model_reset();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic run_xfer(input logic [1:0] r, input logic [1:0] d,
                            input logic [N-1:0] ta, input logic [N-1:0] tb,
                            input logic [N-1:0] sins);
        bus.req  = r;
        bus.dir  = d;
        bus.tx_a = ta;
        bus.tx_b = tb;
        step();
        bus.req = 2'b00;
        for (int k = 0; k < N; k++) begin
            bus.sin = sins[k];
            step();
        end
        step();
        step();
    endtask

    task automatic clear_grants();
        gq_val.delete();
        gq_cyc.delete();
    endtask

    initial begin
        int dc0;
        bus.req  = 2'b00;
        bus.dir  = 2'b00;
        bus.tx_a = '0;
        bus.tx_b = '0;
        bus.sin  = 1'b0;
        reset_dut();
        step();

        // A, right shift
        dc0 = done_count;
        run_xfer(2'b01, 2'b01, 4'b1011, 4'b0000, 4'b1001);
        chk("a_rx", bus.rx_word, 4'b1001);
        chk("a_done_id", bus.done_id, 1'b0);
        chk("a_done_cnt", done_count - dc0, 1);

        // B, left shift
        run_xfer(2'b10, 2'b00, 4'b0000, 4'b1011, 4'b0011);
        chk("b_rx", bus.rx_word, 4'b1100);
        chk("b_done_id", bus.done_id, 1'b1);

        // both requesting: strict alternation starting at A
        reset_dut();
        clear_grants();
        bus.req = 2'b11;
        repeat (24) step();
        bus.req = 2'b00;
        repeat (8) step();
        chk("rr_count", gq_val.size(), 4);
        for (int i = 0; i < gq_val.size(); i++) begin
            chk("rr_order", gq_val[i], (i % 2 == 0) ? 1 : 2);
            if (i > 0) chk("rr_spacing", gq_cyc[i] - gq_cyc[i-1], N + 2);
        end

        // only B: back-to-back even though pointer favours A
        clear_grants();
        bus.req = 2'b10;
        repeat (18) step();
        bus.req = 2'b00;
        repeat (8) step();
        chk("b_only_count", gq_val.size(), 3);
        for (int i = 0; i < gq_val.size(); i++) begin
            chk("b_only_gnt", gq_val[i], 2);
            if (i > 0) chk("b_only_spacing", gq_cyc[i] - gq_cyc[i-1], N + 2);
        end

        // reset after the second shift: no done, next tie goes to A
        bus.req  = 2'b10;
        bus.tx_b = 4'b0110;
        step();
        bus.req = 2'b00;
        step();
        step();
        dc0 = done_count;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        step();
        rst = 1'b1;
        repeat (N + 2) step();
        chk("rst_no_done", done_count - dc0, 0);
        clear_grants();
        bus.req = 2'b11;
        step();
        step();
        bus.req = 2'b00;
        chk("rst_gnt_first", (gq_val.size() > 0) ? gq_val[0] : 0, 1);
        repeat (N + 4) step();

        // request dropped and word changed mid-shift
        dc0 = done_count;
        bus.req  = 2'b01;
        bus.dir  = 2'b01;
        bus.tx_a = 4'b0110;
        step();
        bus.req  = 2'b00;
        bus.tx_a = 4'b1001;
        bus.dir  = 2'b00;
        for (int k = 0; k < N; k++) begin
            bus.sin = k[0] ? 1'b0 : 1'b1;
            step();
        end
        step();
        step();
        chk("drop_rx", bus.rx_word, 4'b0101);
        chk("drop_one_done", done_count - dc0, 1);

        // random traffic with occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            bus.req  = 2'($urandom_range(0, 3));
            bus.dir  = 2'($urandom_range(0, 3));
            bus.tx_a = N'($urandom);
            bus.tx_b = N'($urandom);
            bus.sin  = 1'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                #1;
                model_reset();
                check_outputs();
            end else begin
                rst = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
